pc_fetch_unit: RTL and testbench

//   Program-counter register and instruction-fetch sequencer for KGPminiRISC.
//   - Holds the PC and drives the synchronous instruction memory.
//   - Presents the fetched instruction downstream with a valid/ack handshake.
//   - Exports PC+4 (pc_incremented) to the branch unit; loads the branch

---
 rtl/pc_fetch_unit.sv | 114 +++++++++++
 tb/tb_pc_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch sequencer for
// KGPminiRISC. Issues one imem read per instruction, waits out the memory
// latency, presents the instruction with a valid/ack handshake, and on
// retirement loads the branch unit's next PC and bumps the retire counter.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_LAT = 1,   // legal 1..4
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc_next,
  input  logic               instr_ack,
  input  logic               halt,
  input  logic [31:0]        imem_rdata,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_incremented,
  output logic [31:0]        instr_count,
  output logic               misalign_err,
  output logic               halted
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_VALID,
    S_HALT
  } state_t;

  // Latency counter preload: WAIT lasts exactly IMEM_LAT cycles, ending on cnt==0.
  localparam logic [1:0] CNT_INIT = 2'(IMEM_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cnt;
  logic       accept;

  // Retirement happens only on an ack while an instruction is being presented.
  assign accept = (state == S_VALID) && instr_ack;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Next-state and FSM-decoded outputs.
  // NOTE: every output gets a default before the case; without it a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt   = state;
    imem_en     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem_en   = ~rst;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == 2'd0) state_nxt = S_VALID;
      end
      S_VALID: begin
        instr_valid = 1'b1;
        if (accept) state_nxt = halt ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Datapath: latency counter, instruction capture, PC update, retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      instr        <= 32'd0;
      instr_count  <= 32'd0;
      misalign_err <= 1'b0;
      cnt          <= 2'd0;
    end else begin
      unique case (state)
        S_FETCH: cnt <= CNT_INIT;
        S_WAIT: begin
          if (cnt == 2'd0) instr <= imem_rdata;
          else             cnt   <= cnt - 2'd1;
        end
        S_VALID: begin
          if (accept) begin
            instr_count <= instr_count + 32'd1;
            // A HALT retires in place: pc keeps pointing at the HALT.
            if (!halt) begin
              pc <= {pc_next[31:2], 2'b00};
              if (pc_next[1:0] != 2'b00) misalign_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Word address into imem; higher PC bits are left to the memory to wrap.
  assign imem_addr      = pc[IMEM_AW+1:2];
  assign pc_incremented = pc + 32'd4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: one instance with IMEM_LAT=1 for the main
// handshake/PC sequence, one with IMEM_LAT=3 and a non-zero RESET_PC for the
// reset-during-WAIT case. Expected fetches go into a scoreboard queue when the
// ack (or reset release) is driven and are popped when instr_valid rises.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC_B = 32'h0000_0040;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return 32'hDEAD_BEEF ^ ({22'd0, a} * 32'h9E37_79B1);
  endfunction

  // ---------------- instance A: IMEM_LAT = 1 ----------------
  logic        rst_a, ack_a, halt_a;
  logic [31:0] pc_next_a, rdata_a;
  logic        en_a, valid_a, mis_a, halted_a;
  logic [9:0]  addr_a;
  logic [31:0] instr_a, pc_a, pcinc_a, count_a;

  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_LAT(1), .IMEM_AW(10)) u_a (
    .clk(clk), .rst(rst_a), .pc_next(pc_next_a), .instr_ack(ack_a),
    .halt(halt_a), .imem_rdata(rdata_a), .imem_en(en_a), .imem_addr(addr_a),
    .instr(instr_a), .instr_valid(valid_a), .pc(pc_a),
    .pc_incremented(pcinc_a), .instr_count(count_a),
    .misalign_err(mis_a), .halted(halted_a)
  );

  logic       pe_a;
  logic [9:0] pa_a;
  always @(posedge clk) begin
    pe_a <= en_a;
    pa_a <= addr_a;
  end
  assign rdata_a = pe_a ? mem_word(pa_a) : 32'hBAD0_BAD0;

  // ---------------- instance B: IMEM_LAT = 3 ----------------
  logic        rst_b, ack_b, halt_b;
  logic [31:0] pc_next_b, rdata_b;
  logic        en_b, valid_b, mis_b, halted_b;
  logic [9:0]  addr_b;
  logic [31:0] instr_b, pc_b, pcinc_b, count_b;

  pc_fetch_unit #(.RESET_PC(RESET_PC_B), .IMEM_LAT(3), .IMEM_AW(10)) u_b (
    .clk(clk), .rst(rst_b), .pc_next(pc_next_b), .instr_ack(ack_b),
    .halt(halt_b), .imem_rdata(rdata_b), .imem_en(en_b), .imem_addr(addr_b),
    .instr(instr_b), .instr_valid(valid_b), .pc(pc_b),
    .pc_incremented(pcinc_b), .instr_count(count_b),
    .misalign_err(mis_b), .halted(halted_b)
  );

  logic       pe_b[3];
  logic [9:0] pa_b[3];
  always @(posedge clk) begin
    pe_b[0] <= en_b;
    pa_b[0] <= addr_b;
    for (int i = 1; i < 3; i++) begin
      pe_b[i] <= pe_b[i-1];
      pa_b[i] <= pa_b[i-1];
    end
  end
  assign rdata_b = pe_b[2] ? mem_word(pa_b[2]) : 32'hBAD0_BAD0;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] p);
    exp_t e;
    e.pc    = p;
    e.instr = mem_word(p[11:2]);
    sb.push_back(e);
  endtask

  // Wait (bounded) for instr_valid on the selected instance, check the
  // fetch latency, then pop the scoreboard and compare the presented data.
  task automatic wait_valid(input bit sel, input int exp_cycles);
    int   cycles = 0;
    exp_t e;
    while (!(sel ? valid_b : valid_a) && cycles < 20) begin
      tick();
      cycles++;
    end
    check(sel ? "lat_b" : "lat_a", 32'(cycles), 32'(exp_cycles));
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(sel ? "instr_b" : "instr_a", sel ? instr_b : instr_a, e.instr);
      check(sel ? "pc_b" : "pc_a", sel ? pc_b : pc_a, e.pc);
      check(sel ? "pcinc_b" : "pcinc_a", sel ? pcinc_b : pcinc_a, e.pc + 32'd4);
    end
  endtask

  logic [31:0] pc_m = 32'd0;
  logic [31:0] count_m = 32'd0;
  logic        mis_m = 1'b0;

  // One accepting cycle on instance A, followed by checks of the cycle after.
  task automatic accept_a(input logic [31:0] nxt, input logic h);
    pc_next_a = nxt;
    halt_a    = h;
    ack_a     = 1'b1;
    tick();
    ack_a     = 1'b0;
    halt_a    = 1'b0;
    pc_next_a = 32'h5555_5555;
    count_m++;
    check("count", count_a, count_m);
    if (!h) begin
      pc_m = {nxt[31:2], 2'b00};
      if (nxt[1:0] != 2'b00) mis_m = 1'b1;
      check("fetch_en", {31'd0, en_a}, 32'd1);
      check("fetch_addr", {22'd0, addr_a}, {22'd0, pc_m[11:2]});
      check("pc_load", pc_a, pc_m);
      check("pcinc_load", pcinc_a, pc_m + 32'd4);
      check("misalign", {31'd0, mis_a}, {31'd0, mis_m});
      push_exp(pc_m);
      wait_valid(1'b0, 2);
    end else begin
      check("halted", {31'd0, halted_a}, 32'd1);
      check("halt_pc", pc_a, pc_m);
      check("halt_en", {31'd0, en_a}, 32'd0);
      check("halt_valid", {31'd0, valid_a}, 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] hold_instr;
    rst_a = 1'b1; ack_a = 1'b0; halt_a = 1'b0; pc_next_a = 32'd0;
    rst_b = 1'b1; ack_b = 1'b0; halt_b = 1'b0; pc_next_b = 32'd0;

    // Test 1: reset for two cycles, then first fetch of DEADBEEF at pc 0.
    tick();
    check("rst_en", {31'd0, en_a}, 32'd0);
    check("rst_valid", {31'd0, valid_a}, 32'd0);
    tick();
    check("rst_pc", pc_a, 32'd0);
    check("rst_instr", instr_a, 32'd0);
    check("rst_count", count_a, 32'd0);
    check("rst_mis", {31'd0, mis_a}, 32'd0);
    check("rst_halted", {31'd0, halted_a}, 32'd0);
    rst_a = 1'b0;
    #1;
    check("first_en", {31'd0, en_a}, 32'd1);
    check("first_addr", {22'd0, addr_a}, 32'd0);
    push_exp(32'd0);
    wait_valid(1'b0, 2);
    check("deadbeef", instr_a, 32'hDEAD_BEEF);

    // Test 3: hold ack low for 5 cycles; everything stays put.
    hold_instr = instr_a;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_instr", instr_a, hold_instr);
      check("hold_pc", pc_a, 32'd0);
      check("hold_valid", {31'd0, valid_a}, 32'd1);
      check("hold_en", {31'd0, en_a}, 32'd0);
    end

    // Test 2: aligned branch target 200 -> imem_addr 50, count 1.
    accept_a(32'd200, 1'b0);
    // Test 4: misaligned target sets the sticky flag; aligned one keeps it.
    accept_a(32'h0000_0202, 1'b0);
    accept_a(32'hFFFF_FFFC, 1'b0);   // pc_incremented wraps to 0
    accept_a(32'd100, 1'b0);
    // Test 5: HALT at pc 100, then further acks are ignored.
    accept_a(32'd8, 1'b1);
    ack_a = 1'b1;
    pc_next_a = 32'h0000_0044;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("h_pc", pc_a, 32'd100);
      check("h_count", count_a, count_m);
      check("h_en", {31'd0, en_a}, 32'd0);
      check("h_halted", {31'd0, halted_a}, 32'd1);
      check("h_mis", {31'd0, mis_a}, 32'd1);
    end
    ack_a = 1'b0;

    // Test 6: IMEM_LAT=3, reset during the second WAIT cycle.
    rst_b = 1'b0;              // instance B has been in reset since time 0
    #1;
    check("b_fetch_en", {31'd0, en_b}, 32'd1);
    tick();                    // WAIT cycle 1
    tick();                    // WAIT cycle 2
    rst_b = 1'b1;
    tick();
    check("b_rst_pc", pc_b, RESET_PC_B);
    check("b_rst_valid", {31'd0, valid_b}, 32'd0);
    check("b_rst_en", {31'd0, en_b}, 32'd0);
    rst_b = 1'b0;
    #1;
    check("b_refetch_en", {31'd0, en_b}, 32'd1);
    check("b_refetch_addr", {22'd0, addr_b}, {22'd0, RESET_PC_B[11:2]});
    push_exp(RESET_PC_B);
    wait_valid(1'b1, 4);
    // One more fetch on B to confirm the LAT=3 steady-state path.
    pc_next_b = 32'h0000_0010;
    ack_b = 1'b1;
    tick();
    ack_b = 1'b0;
    check("b_count", count_b, 32'd1);
    push_exp(32'h0000_0010);
    wait_valid(1'b1, 4);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
